// File: rtl/bft_pkg.sv
// ----------------------------------------------------------------------------
// bft_pkg
// Shared definitions for the BFT leaf transmit path: packet field layout,
// control port codes, the packet struct, the transmit FSM state type and the
// saturating credit update helper.
//
// Packet layout (49 bits):
//   [48]    valid
//   [47:43] destination leaf
//   [42:39] destination port
//   [38:32] receiver write address
//   [31:0]  payload
// ----------------------------------------------------------------------------
package bft_pkg;

    localparam int PACKET_BITS           = 49;
    localparam int PAYLOAD_BITS          = 32;
    localparam int NUM_LEAF_BITS         = 5;
    localparam int NUM_PORT_BITS         = 4;
    localparam int NUM_ADDR_BITS         = 7;
    localparam int NUM_OUT_PORTS         = 3;
    localparam int FREESPACE_UPDATE_SIZE = 64;

    // Field offsets (LSB positions) inside a packet
    localparam int VALID_BIT   = 48;
    localparam int LEAF_LSB    = 43;
    localparam int PORT_LSB    = 39;
    localparam int ADDR_LSB    = 32;
    localparam int PAYLOAD_LSB = 0;

    // A destination is {leaf, port}
    localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;

    // Credit needs one bit more than the address to hold the full depth (128)
    localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(1 << NUM_ADDR_BITS);
    localparam logic [CREDIT_BITS:0]   FS_INC     = (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE);
    localparam logic [CREDIT_BITS:0]   CREDIT_ONE = (CREDIT_BITS+1)'(1);

    // Control packet port codes
    localparam logic [NUM_PORT_BITS-1:0] CFG_PORT       = 4'd0;
    localparam logic [NUM_PORT_BITS-1:0] FREESPACE_PORT = 4'd1;

    typedef struct packed {
        logic                     vld;
        logic [NUM_LEAF_BITS-1:0] leaf;
        logic [NUM_PORT_BITS-1:0] port;
        logic [NUM_ADDR_BITS-1:0] addr;
        logic [PAYLOAD_BITS-1:0]  payload;
    } bft_pkt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    // Next credit value: add a freespace grant and/or consume one packet,
    // saturating at the receiver depth. The sum is computed one bit wider so
    // 128 + 64 does not wrap before the clamp.
    function automatic logic [CREDIT_BITS-1:0] credit_next(
        input logic [CREDIT_BITS-1:0] cur,
        input logic                   add,
        input logic                   dec
    );
        logic [CREDIT_BITS:0] sum;
        sum = {1'b0, cur};
        if (add) sum = sum + FS_INC;
        if (dec) sum = sum - CREDIT_ONE;
        if (sum > {1'b0, CREDIT_MAX}) sum = {1'b0, CREDIT_MAX};
        return sum[CREDIT_BITS-1:0];
    endfunction

endpackage

// File: rtl/bft_leaf_tx_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with one-hot grant. The search starts at the pointer;
// after a grant the pointer moves to the requester just after the winner.
// With no grant the pointer holds. Reset pointer is index 0 (user port 1).
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   req_i    N request lines (index 0 = port 1)
//   gnt_o    one-hot grant, combinational from req_i and the pointer
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        int            tmp;
        logic [PW-1:0] idx;
        logic          found;
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        tmp   = 0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            // Rotate the search order so it begins at the pointer
            tmp = int'(ptr_q) + k;
            if (tmp >= N) tmp = tmp - N;
            idx = PW'(tmp);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = (idx == PW'(N-1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bft_leaf_tx.sv
// ----------------------------------------------------------------------------
// bft_leaf_tx
// Transmit half of a BFT leaf port. Packs up to NUM_OUT_PORTS user streams
// into 49-bit BFT packets on the upstream link. Destinations come from config
// packets; flow control uses receiver-issued freespace credits.
//
// Ports:
//   ap_clk                   clock
//   ap_rst_n                 asynchronous active-low reset
//   ap_start                 enables transmission (latched into RUN)
//   din_leaf_bft2interface   control packets (config / freespace)
//   dout_leaf_interface2bft  outgoing packet, registered
//   din_leaf_user2interface  user data, port 1 in the LSB slice
//   vld_user2interface       user valid, one per port
//   ack_interface2user       user accept, one per port
//   dbg_state_o              current transmit FSM state
//   pkt_cnt                  per-port grant counters (BFT_TX_PKT_CNT_EN only)
//
// Optional feature macro: BFT_TX_PKT_CNT_EN adds pkt_cnt, one 32-bit wrapping
// counter of grants per port, cleared by reset.
//
// User handshake: the user presents data with vld high and holds both until
// ack. ack is combinational from registered state and vld; a transfer happens
// in any cycle where vld and ack are both high, and the packet appears on dout
// on the following cycle.
// ----------------------------------------------------------------------------
module bft_leaf_tx
    import bft_pkg::*;
(
    input  logic                                  ap_clk,
    input  logic                                  ap_rst_n,
    input  logic                                  ap_start,
    input  logic [PACKET_BITS-1:0]                din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    output tx_state_e                             dbg_state_o
`ifdef BFT_TX_PKT_CNT_EN
    ,
    output logic [NUM_OUT_PORTS*32-1:0]           pkt_cnt
`endif
);

    // ------------------------------------------------------------------
    // Control packet decode
    // ------------------------------------------------------------------
    bft_pkt_t           ctl;
    logic [3:0]         ctl_p;
    logic               ctl_p_ok;
    logic               cfg_hit;
    logic               fs_hit;
    logic               ctl_unused;

    assign ctl        = bft_pkt_t'(din_leaf_bft2interface);
    assign ctl_p      = ctl.addr[3:0];
    assign ctl_p_ok   = ctl.vld && (ctl_p != 4'd0) && (ctl_p <= 4'(NUM_OUT_PORTS));
    assign cfg_hit    = ctl_p_ok && (ctl.port == CFG_PORT);
    assign fs_hit     = ctl_p_ok && (ctl.port == FREESPACE_PORT);
    assign ctl_unused = ^{ctl.leaf, ctl.addr[NUM_ADDR_BITS-1:4],
                          ctl.payload[PAYLOAD_BITS-1:DEST_BITS]};

    // ------------------------------------------------------------------
    // Global FSM
    // ------------------------------------------------------------------
    tx_state_e state_q;
    tx_state_e state_d;
    logic      run;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ap_start) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    assign run         = (state_q == ST_RUN);
    assign dbg_state_o = state_q;

    // ------------------------------------------------------------------
    // Per-port state
    // ------------------------------------------------------------------
    logic [NUM_OUT_PORTS-1:0] cfg_q;
    logic [NUM_OUT_PORTS-1:0] cfg_d;
    logic [DEST_BITS-1:0]     dest_q   [NUM_OUT_PORTS];
    logic [DEST_BITS-1:0]     dest_d   [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] waddr_q  [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] waddr_d  [NUM_OUT_PORTS];

    logic [NUM_OUT_PORTS-1:0] req;
    logic [NUM_OUT_PORTS-1:0] gnt;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            req[i] = run && cfg_q[i] && vld_user2interface[i] && (credit_q[i] != '0);
        end
    end

    rr_arbiter #(
        .N (NUM_OUT_PORTS)
    ) u_arb (
        .clk_i  (ap_clk),
        .rst_ni (ap_rst_n),
        .req_i  (req),
        .gnt_o  (gnt)
    );

    assign ack_interface2user = gnt;

    // Next-state for per-port registers. A grant always reads the current
    // (registered) dest, so a config landing in the same cycle only affects
    // later grants.
    always_comb begin
        logic sel;
        sel   = 1'b0;
        cfg_d = cfg_q;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            sel       = (ctl_p == 4'(i + 1));
            dest_d[i] = dest_q[i];
            if (cfg_hit && sel) begin
                cfg_d[i]  = 1'b1;
                dest_d[i] = ctl.payload[DEST_BITS-1:0];
            end
            credit_d[i] = credit_next(credit_q[i], fs_hit && sel, gnt[i]);
            waddr_d[i]  = waddr_q[i] + {{(NUM_ADDR_BITS-1){1'b0}}, gnt[i]};
        end
    end

    // ------------------------------------------------------------------
    // Outgoing packet
    // ------------------------------------------------------------------
    bft_pkt_t                pkt_d;
    logic [PACKET_BITS-1:0]  dout_q;

    always_comb begin
        pkt_d = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (gnt[i]) begin
                pkt_d.vld               = 1'b1;
                {pkt_d.leaf, pkt_d.port} = dest_q[i];
                pkt_d.addr              = waddr_q[i];
                pkt_d.payload           = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    assign dout_leaf_interface2bft = dout_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            dout_q  <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                dest_q[i]   <= '0;
                credit_q[i] <= CREDIT_MAX;
                waddr_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            dout_q   <= pkt_d;
            dest_q   <= dest_d;
            credit_q <= credit_d;
            waddr_q  <= waddr_d;
        end
    end

`ifdef BFT_TX_PKT_CNT_EN
    // ------------------------------------------------------------------
    // Optional per-port grant counters
    // ------------------------------------------------------------------
    logic [31:0] cnt_q [NUM_OUT_PORTS];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) cnt_q[i] <= cnt_q[i] + {31'd0, gnt[i]};
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) pkt_cnt[i*32 +: 32] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_bft_leaf_tx.sv
module tb_bft_leaf_tx;
  import bft_pkg::*;

  // ---------------- clock / reset ----------------
  logic                                  ap_clk;
  logic                                  ap_rst_n;
  logic                                  ap_start;
  logic [PACKET_BITS-1:0]                din_ctl;
  logic [PACKET_BITS-1:0]                dout;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
  logic [NUM_OUT_PORTS-1:0]              vld;
  logic [NUM_OUT_PORTS-1:0]              ack;
  tx_state_e                             dbg_state;
`ifdef BFT_TX_PKT_CNT_EN
  logic [NUM_OUT_PORTS*32-1:0]           pkt_cnt;
`endif

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  bft_leaf_tx dut (
    .ap_clk                  (ap_clk),
    .ap_rst_n                (ap_rst_n),
    .ap_start                (ap_start),
    .din_leaf_bft2interface  (din_ctl),
    .dout_leaf_interface2bft (dout),
    .din_leaf_user2interface (din_user),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .dbg_state_o             (dbg_state)
`ifdef BFT_TX_PKT_CNT_EN
    ,
    .pkt_cnt                 (pkt_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [PACKET_BITS-1:0] exp_q[$];
  int n_cmp;
  int n_fail;
  logic [6:0] addr_m [1:3];
  logic [8:0] dest_m [1:3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: every valid packet on dout must match the queue head
  always @(negedge ap_clk) begin
    if (ap_rst_n === 1'b1 && dout[48] === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dout_unexpected: got %h, expected no packet (t=%0t)", dout, $time);
      end else begin
        check("dout_pkt", {15'd0, dout}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int p = 1; p <= 3; p++) begin
      addr_m[p] = '0;
      dest_m[p] = '0;
    end
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    vld      = '0;
    din_ctl  = '0;
    din_user = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    exp_q.delete();
    model_reset();
    tick();
  endtask

  task automatic send_ctl(input logic [3:0] pf, input logic [3:0] p, input logic [31:0] pl);
    din_ctl = {1'b1, 5'd0, pf, 3'd0, p, pl};
    tick();
    din_ctl = '0;
  endtask

  task automatic cfg_port(input int p, input logic [4:0] leaf, input logic [3:0] dport);
    send_ctl(CFG_PORT, 4'(p), {23'd0, leaf, dport});
    dest_m[p] = {leaf, dport};
  endtask

  // present one word on port p, wait (bounded) for ack, queue the expected packet
  task automatic send_one(input int p, input logic [31:0] data);
    bit got;
    int c;
    got = 1'b0;
    c   = 0;
    din_user[(p-1)*32 +: 32] = data;
    vld[p-1] = 1'b1;
    while (!got && c < 16) begin
      @(negedge ap_clk);
      if (ack[p-1]) begin
        got = 1'b1;
        exp_q.push_back({1'b1, dest_m[p], addr_m[p], data});
        addr_m[p] = addr_m[p] + 7'd1;
      end
      @(posedge ap_clk);
      #1;
      c++;
    end
    check($sformatf("ack_port%0d", p), {63'd0, got}, 64'd1);
    vld[p-1] = 1'b0;
  endtask

  // hold vld on port p and require no ack; vld stays high afterwards
  task automatic expect_blocked(input int p, input int cycles, input logic [31:0] data, input string name);
    bit any;
    any = 1'b0;
    din_user[(p-1)*32 +: 32] = data;
    vld[p-1] = 1'b1;
    repeat (cycles) begin
      @(negedge ap_clk);
      if (ack[p-1]) any = 1'b1;
      @(posedge ap_clk);
      #1;
    end
    check(name, {63'd0, any}, 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NUM_OUT_PORTS-1:0] oh;
    logic [23:0] seq [1:3];
    int e;

    n_cmp    = 0;
    n_fail   = 0;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    din_ctl  = '0;
    din_user = '0;
    vld      = '0;
    model_reset();

    // reset state
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_dout", {15'd0, dout}, 64'd0);
    check("rst_ack", {61'd0, ack}, 64'd0);
    check("rst_state", {63'd0, dbg_state}, {63'd0, ST_IDLE});
    ap_rst_n = 1'b1;
    tick();

    // T1: configured + valid but not started -> no ack; start -> packet
    cfg_port(1, 5'd3, 4'd2);
    din_user[31:0] = 32'hA5A5_0001;
    vld[0] = 1'b1;
    repeat (3) begin
      @(negedge ap_clk);
      check("ack_idle", {61'd0, ack}, 64'd0);
      @(posedge ap_clk);
      #1;
    end
    check("state_idle", {63'd0, dbg_state}, {63'd0, ST_IDLE});
    ap_start = 1'b1;
    tick();
    check("state_run", {63'd0, dbg_state}, {63'd0, ST_RUN});
    send_one(1, 32'hA5A5_0001);
    check("t1_dout_literal", {15'd0, dout}, {15'd0, 49'h1_1900_A5A5_0001});
    tick();

    // T2: three ports, continuous valid -> grants 1,2,3,1,...
    do_reset();
    cfg_port(1, 5'd1, 4'd1);
    cfg_port(2, 5'd2, 4'd2);
    cfg_port(3, 5'd4, 4'd3);
    for (int p = 1; p <= 3; p++) begin
      seq[p] = 24'd0;
      din_user[(p-1)*32 +: 32] = {8'(p), seq[p]};
    end
    vld = 3'b111;
    for (int k = 0; k < 9; k++) begin
      e  = (k % 3) + 1;
      oh = 3'(1 << (e - 1));
      @(negedge ap_clk);
      check("rr_ack", {61'd0, ack}, {61'd0, oh});
      exp_q.push_back({1'b1, dest_m[e], addr_m[e], 8'(e), seq[e]});
      addr_m[e] = addr_m[e] + 7'd1;
      @(posedge ap_clk);
      #1;
      seq[e] = seq[e] + 24'd1;
      din_user[(e-1)*32 +: 32] = {8'(e), seq[e]};
    end
    vld = '0;
    check("rr_last_dout", {15'd0, dout}, {15'd0, 1'b1, 5'd4, 4'd3, 7'd2, 8'd3, 24'd2});
    tick();

    // T3: credit exhaustion on port 1, port 2 unaffected, freespace refill, addr wrap
    do_reset();
    cfg_port(1, 5'd7, 4'd5);
    cfg_port(2, 5'd1, 4'd9);
    for (int i = 0; i < 128; i++) send_one(1, 32'h1000_0000 + i);
    expect_blocked(1, 6, 32'h1000_0080, "credit0_block");
    send_one(2, 32'h2000_0000);
    send_one(2, 32'h2000_0001);
    send_ctl(FREESPACE_PORT, 4'd1, 32'd0);
    send_one(1, 32'h1000_0080);
    check("wrap_addr", {57'd0, dout[38:32]}, 64'd0);
    for (int i = 1; i < 64; i++) send_one(1, 32'h1000_0080 + i);
    expect_blocked(1, 6, 32'h1000_00C0, "credit_refill_block");
    tick();

    // T4: freespace + grant in the same cycle at full credit saturates at 128
    do_reset();
    cfg_port(2, 5'd2, 4'd6);
    din_ctl = {1'b1, 5'd0, FREESPACE_PORT, 3'd0, 4'd2, 32'd0};
    send_one(2, 32'h3000_0000);
    din_ctl = '0;
    for (int i = 1; i <= 128; i++) send_one(2, 32'h3000_0000 + i);
    expect_blocked(2, 6, 32'h3000_0081, "sat_block");
    tick();

    // T5: asynchronous reset mid-stream
    do_reset();
    cfg_port(1, 5'd3, 4'd2);
    send_one(1, 32'h4000_0000);
    send_one(1, 32'h4000_0001);
    din_user[31:0] = 32'h4000_0002;
    vld[0] = 1'b1;
    @(negedge ap_clk);
    check("midrst_ack", {61'd0, ack}, 64'd1);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("midrst_dout", {15'd0, dout}, 64'd0);
    check("midrst_state", {63'd0, dbg_state}, {63'd0, ST_IDLE});
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    model_reset();
`ifdef BFT_TX_PKT_CNT_EN
    check("pkt_cnt_reset", {32'd0, pkt_cnt[31:0]}, 64'd0);
`endif
    expect_blocked(1, 4, 32'h4000_0002, "unconfigured_after_rst");
    cfg_port(1, 5'd3, 4'd2);
    send_one(1, 32'h4000_0002);
    check("addr_after_rst", {57'd0, dout[38:32]}, 64'd0);
    for (int i = 1; i < 128; i++) send_one(1, 32'h4000_0002 + i);
`ifdef BFT_TX_PKT_CNT_EN
    check("pkt_cnt_count", {32'd0, pkt_cnt[31:0]}, 64'd128);
`endif
    expect_blocked(1, 6, 32'h4000_0082, "credit128_after_rst");

    repeat (3) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
